aes_block_collect: RTL

AES_BLOCK_COLLECT -- requirements
Module: aes_block_collect

---
 rtl/aes_block_collect_pkg.sv | 20 ++
 rtl/aes_skid_buf2.sv | 66 ++++++
 rtl/aes_block_collect.sv | 62 ++++++
 3 files changed

// File: rtl/aes_block_collect_pkg.sv
// Shared AES definitions: block and round-state types, final round index,
// and the occupancy encoding of the 2-entry output skid buffer.
package aes_block_collect_pkg;

  localparam int unsigned AES_BLOCK_W = 128;
  localparam int unsigned AES_STATE_W = 5;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;
  typedef logic [AES_STATE_W-1:0] aes_round_state_t;

  // Round index carried by a block that has completed all AES-128 rounds.
  localparam aes_round_state_t AES_FINAL_STATE = 5'd10;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/aes_skid_buf2.sv
// Two-entry FIFO: occupancy FSM, 1-bit head/tail wrap pointers, storage.
// Handshake: push writes push_data at the tail, pop retires the head entry;
// the caller never pushes at OCC_TWO without a same-cycle pop and never pops
// at OCC_EMPTY. occ is exported so the FSM state is directly observable.
module aes_skid_buf2
  import aes_block_collect_pkg::*;
#(
  parameter int unsigned W = 128
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] head_data,
  output occ_e         occ
);

  occ_e         occ_q;
  occ_e         occ_d;
  logic         rd_ptr;
  logic         wr_ptr;
  logic [W-1:0] mem [0:1];

  // Occupancy state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) occ_q <= OCC_EMPTY;
    else        occ_q <= occ_d;
  end

  // Occupancy next state: push alone goes up, pop alone goes down, both hold.
  always_comb begin
    occ_d = occ_q;
    unique case ({push, pop})
      2'b10: begin
        if (occ_q == OCC_EMPTY)    occ_d = OCC_ONE;
        else if (occ_q == OCC_ONE) occ_d = OCC_TWO;
      end
      2'b01: begin
        if (occ_q == OCC_TWO)      occ_d = OCC_ONE;
        else if (occ_q == OCC_ONE) occ_d = OCC_EMPTY;
      end
      default: occ_d = occ_q;
    endcase
  end

  // Storage and pointers: tail slot written on push, head advances on pop.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

  assign head_data = mem[rd_ptr];
  assign occ       = occ_q;

endmodule

// File: rtl/aes_block_collect.sv
// Collects completed AES blocks from the round datapath into a 2-entry
// buffer and drains them to the output FIFO, stalling the datapath only
// when a final block cannot be taken this cycle.
module aes_block_collect
  import aes_block_collect_pkg::*;
#(
  parameter aes_round_state_t FINAL_STATE = AES_FINAL_STATE
) (
  input  logic             clk,
  input  logic             n_rst,
  input  aes_block_t       i_round_block,
  input  aes_round_state_t i_round_state,
  input  logic             i_round_valid,
  input  logic             i_fifo_full,
  output aes_block_t       o_block_out,
  output logic             o_write_fifo,
  output logic             o_stall,
  output logic [7:0]       o_blocks_done,
  output logic             o_state_err
);

  occ_e       occ;
  aes_block_t head;
  logic       is_final;
  logic       is_illegal;
  logic       pop;
  logic       accept;

  // Classify the incoming block and derive the push/pop handshake.
  always_comb begin
    is_final   = i_round_valid && (i_round_state == FINAL_STATE);
    is_illegal = i_round_valid && (i_round_state > FINAL_STATE);
    pop        = (occ != OCC_EMPTY) && !i_fifo_full;
    // A full buffer still accepts when the head leaves in the same cycle.
    accept     = is_final && ((occ != OCC_TWO) || pop);
    o_stall    = is_final && !accept;
    o_write_fifo = pop;
    o_block_out  = (occ != OCC_EMPTY) ? head : '0;
  end

  aes_skid_buf2 #(.W(AES_BLOCK_W)) u_buf (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (accept),
    .pop       (pop),
    .push_data (i_round_block),
    .head_data (head),
    .occ       (occ)
  );

  // Written-block counter (free-running modulo 256) and sticky state error.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      o_blocks_done <= 8'd0;
      o_state_err   <= 1'b0;
    end else begin
      if (pop)        o_blocks_done <= o_blocks_done + 8'd1;
      if (is_illegal) o_state_err   <= 1'b1;
    end
  end

endmodule
